cache_2way: RTL

Parametrised two-way set-associative, write-back, write-allocate cache between the processor and the 128-bit-line main memory. It is the successor to the direct-mapped cache and keeps the same processor and memory handshake. It adds configurable set count, two ways per set with LRU replacement, and optional hit/miss performance counters. A hit completes with zero stall; a miss stalls the processor until the line is written back (if dirty) and refilled.

---
 rtl/cache_2way_if.sv | 41 ++++
 rtl/cache_2way.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_if.sv
// -----------------------------------------------------------------------------
// cache_2way_if
// Processor-side and memory-side handshake bundle for cache_2way.
//   slave  : the cache view (takes processor requests, drives memory requests)
//   master : the environment view (processor + main memory)
// Processor side : proc_read, proc_write, proc_addr, proc_wdata -> cache
//                  proc_rdata, proc_stall                         <- cache
// Memory side    : mem_read, mem_write, mem_addr, mem_wdata       <- cache
//                  mem_rdata, mem_ready                           -> cache
// -----------------------------------------------------------------------------
interface cache_2way_if #(
    parameter int ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cache_2way.sv
// -----------------------------------------------------------------------------
// cache_2way
// Two-way set-associative, write-back, write-allocate cache with 128-bit lines
// and one LRU bit per set. Hits complete with zero stall; a miss stalls the
// processor while the victim is written back (if dirty) and the line refilled.
//
// Parameters : SETS   number of sets (power of two, >= 2)
//              ADDR_W processor word-address width
// Ports      : clk          clock
//              proc_reset_n asynchronous active-low reset
//              bus          cache_2way_if.slave (processor + memory handshake)
//              hit_cnt      hit counter (0 unless CACHE_PERF_CNT_EN)
//              miss_cnt     miss counter (0 unless CACHE_PERF_CNT_EN)
// Build option: define CACHE_PERF_CNT_EN to build the hit/miss counters.
// -----------------------------------------------------------------------------
module cache_2way #(
    parameter int SETS   = 4,
    parameter int ADDR_W = 30
) (
    input  logic               clk,
    input  logic               proc_reset_n,
    cache_2way_if.slave        bus,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Storage indexed [way][set]
    logic [1:0][SETS-1:0]             valid_q;
    logic [1:0][SETS-1:0]             dirty_q;
    logic [1:0][SETS-1:0][TAG_W-1:0]  tag_q;
    logic [1:0][SETS-1:0][127:0]      data_q;
    logic [SETS-1:0]                  lru_q;    // way to evict next
    logic                             victim_q; // way latched at miss time

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [TAG_W-1:0] tag;
    logic             req;
    logic             hit0, hit1, hit, miss;
    logic             hit_way;
    logic             victim_c;
    logic [127:0]     hit_line;

    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-3:0]  mem_addr;
    logic [127:0]       mem_wdata;

    assign off  = bus.proc_addr[1:0];
    assign idx  = bus.proc_addr[IDX_W+1:2];
    assign tag  = bus.proc_addr[ADDR_W-1:IDX_W+2];
    assign req  = bus.proc_read | bus.proc_write;

    assign hit0    = req & valid_q[0][idx] & (tag_q[0][idx] == tag);
    assign hit1    = req & valid_q[1][idx] & (tag_q[1][idx] == tag);
    assign hit     = hit0 | hit1;
    assign miss    = req & ~hit;
    assign hit_way = hit1;

    // Fill empty ways first (way0 before way1); only a full set uses LRU.
    always_comb begin
        victim_c = lru_q[idx];
        if (!valid_q[0][idx]) begin
            victim_c = 1'b0;
        end else if (!valid_q[1][idx]) begin
            victim_c = 1'b1;
        end
    end

    assign hit_line       = data_q[hit_way][idx];
    assign bus.proc_stall = miss;
    assign bus.proc_rdata = (bus.proc_read && hit) ? hit_line[{off, 5'd0} +: 32] : 32'd0;

    // State register
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory-side outputs; the memory strobes are decoded from
    // the state register alone, so they change only at clock edges.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = dirty_q[victim_c][idx] ? WB : REFILL;
                end
            end
            WB: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[victim_q][idx], idx};
                mem_wdata = data_q[victim_q][idx];
                if (bus.mem_ready) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_read = 1'b1;
                mem_addr = {tag, idx};
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    // Tag/data arrays, valid/dirty/LRU bits and the latched victim way
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            valid_q  <= '0;
            dirty_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        lru_q[idx] <= ~hit_way;
                        if (bus.proc_write) begin
                            data_q[hit_way][idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
                            dirty_q[hit_way][idx] <= 1'b1;
                        end
                    end else if (miss) begin
                        victim_q <= victim_c;
                    end
                end
                WB: begin
                    if (bus.mem_ready) begin
                        dirty_q[victim_q][idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (bus.mem_ready) begin
                        data_q[victim_q][idx]  <= bus.mem_rdata;
                        tag_q[victim_q][idx]   <= tag;
                        valid_q[victim_q][idx] <= 1'b1;
                        dirty_q[victim_q][idx] <= 1'b0;
                        lru_q[idx]             <= ~victim_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // A miss is counted once, in the IDLE cycle that starts its handling.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule
